// File: rtl/alu_step_ctrl.sv
// Step-button sequencer for the switch ALU demo: load A -> load B -> execute -> show.
// Define BTN_DEBOUNCE_EN to insert a DB_CYC-cycle stability filter on the button.

module alu_step_ctrl #(
  parameter int DW      = 32,
  parameter int SW_W    = 8,
  parameter int ALU_LAT = 1,
  parameter int DB_CYC  = 20000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] sw,
  input  logic [2:0]      op_sw,
  input  logic            btn,
  output logic [2:0]      alu_op,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [DW-1:0]   alu_y,
  output logic [DW-1:0]   disp_val,
  output logic [1:0]      stage,
  output logic            busy
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    SHOW   = 2'd3
  } state_e;

  localparam int              LatW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(ALU_LAT - 1);

  if (ALU_LAT < 1 || DB_CYC < 1) begin : g_bad_param
    $error("alu_step_ctrl: ALU_LAT and DB_CYC must both be at least 1");
  end

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   r_q, r_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic [2:0]      op_q, op_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic [1:0]      sync_q, sync_d;
  logic            lvl_prev_q, lvl_prev_d;
  logic            step_q, step_d;
  logic            btn_level;
  logic [DW-1:0]   sw_ext;

  assign sw_ext = DW'(sw);

  // Two-flop synchronizer; the button is fully asynchronous to clk.
  assign sync_d = {sync_q[0], btn};

`ifdef BTN_DEBOUNCE_EN
  localparam int DbW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           filt_q, filt_d;

  // The filtered level follows the synchronized level only after it has
  // disagreed for DB_CYC consecutive cycles; any bounce restarts the count.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync_q[1] != filt_q) begin
      if (db_cnt_q == DbW'(DB_CYC - 1)) begin
        filt_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign btn_level = filt_q;
`else
  assign btn_level = sync_q[1];
`endif

  assign lvl_prev_d = btn_level;
  assign step_d     = btn_level & ~lvl_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      lvl_prev_q <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      lvl_prev_q <= lvl_prev_d;
      step_q     <= step_d;
    end
  end

  // Sequencer; steps arriving in EXEC fall through the default hold and are lost.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    op_d      = op_q;
    lat_cnt_d = '0;
    unique case (state_q)
      LOAD_A: begin
        if (step_q) begin
          a_d     = sw_ext;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (step_q) begin
          b_d     = sw_ext;
          op_d    = op_sw;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt_q == LatLast) begin
          r_d     = alu_y;
          state_d = SHOW;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (step_q) begin
          a_d     = r_q;
          state_d = LOAD_B;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // Display is registered so reset forces it to zero; it shows the result as
  // soon as SHOW is entered and freezes on the last operand during EXEC.
  always_comb begin
    disp_d = disp_q;
    if (state_d == SHOW) begin
      disp_d = r_d;
    end else if (state_d == LOAD_A || state_d == LOAD_B) begin
      disp_d = sw_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD_A;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      op_q      <= '0;
      disp_q    <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      r_q       <= r_d;
      op_q      <= op_d;
      disp_q    <= disp_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign disp_val = disp_q;
  assign stage    = state_q;
  assign busy     = (state_q == EXEC);

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Self-checking bench for alu_step_ctrl: a pipelined toy ALU, a behavioural reference
// model compared every cycle, and directed scenarios with literal expectations.

module tb_alu_step_ctrl;

  localparam int DW      = 32;
  localparam int SW_W    = 8;
  localparam int ALU_LAT = 3;
  localparam int DB_CYC  = 16;
  localparam int Settle  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            btn = 1'b0;
  logic [SW_W-1:0] sw = '0;
  logic [2:0]      opSw = '0;
  logic [2:0]      aluOp;
  logic [DW-1:0]   aluA, aluB, aluY, dispVal;
  logic [1:0]      stage;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  alu_step_ctrl #(
    .DW(DW), .SW_W(SW_W), .ALU_LAT(ALU_LAT), .DB_CYC(DB_CYC)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .op_sw(opSw), .btn(btn),
    .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB), .alu_y(aluY),
    .disp_val(dispVal), .stage(stage), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    aluFn = a + b;
      3'd1:    aluFn = a - b;
      3'd2:    aluFn = a & b;
      3'd3:    aluFn = a | b;
      3'd4:    aluFn = a ^ b;
      3'd5:    aluFn = a * b;
      3'd6:    aluFn = a << b[4:0];
      default: aluFn = a >> b[4:0];
    endcase
  endfunction

  // Toy ALU with ALU_LAT-1 register stages, so its result is stale until the latency has elapsed.
  logic [31:0] pipe1 = '0;
  logic [31:0] pipe2 = '0;
  always @(posedge clk) begin
    pipe1 <= aluFn(aluA, aluB, aluOp);
    pipe2 <= pipe1;
  end
  assign aluY = pipe2;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state
  int          mStage = 0;
  int          mExecN = 0;
  logic [31:0] mA = '0, mB = '0, mR = '0, mDisp = '0;
  logic [2:0]  mOp = '0;
  logic        sy1 = 0, sy2 = 0, lv1 = 0, lv2 = 0, lv3 = 0, filt = 0, prevS = 0;
  int          run = 0;

  task automatic modelReset();
    mStage = 0; mExecN = 0; mA = '0; mB = '0; mR = '0; mDisp = '0; mOp = '0;
    sy1 = 0; sy2 = 0; lv1 = 0; lv2 = 0; lv3 = 0; filt = 0; prevS = 0; run = 0;
  endtask

  initial begin : refModel
    logic step, lvl;
`ifdef BTN_DEBOUNCE_EN
    logic sval;
`endif
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        modelReset();
      end else begin
        // A step acts two edges after the clean level first reads high.
        step = lv2 & ~lv3;
`ifdef BTN_DEBOUNCE_EN
        sval = sy2;
`endif
        sy2 = sy1;
        sy1 = btn;
`ifdef BTN_DEBOUNCE_EN
        if (sval == prevS) run++; else run = 1;
        prevS = sval;
        if (sval != filt && run >= DB_CYC) filt = sval;
        lvl = filt;
`else
        lvl = sy2;
`endif
        lv3 = lv2; lv2 = lv1; lv1 = lvl;
        case (mStage)
          0: if (step) begin mA = 32'(sw); mStage = 1; end
          1: if (step) begin mB = 32'(sw); mOp = opSw; mStage = 2; mExecN = 0; end
          2: begin
            mExecN++;
            if (mExecN == ALU_LAT) begin mR = aluFn(mA, mB, mOp); mStage = 3; end
          end
          default: if (step) begin mA = mR; mStage = 1; end
        endcase
        if (mStage == 3) mDisp = mR;
        else if (mStage < 2) mDisp = 32'(sw);
      end
    end
  end

  initial begin : compareProc
    forever begin
      @(posedge clk);
      #2;
      checkOutput("cyc_stage", 32'(stage), 32'(mStage));
      checkOutput("cyc_busy", 32'(busy), 32'(mStage == 2));
      checkOutput("cyc_alu_a", aluA, mA);
      checkOutput("cyc_alu_b", aluB, mB);
      checkOutput("cyc_alu_op", 32'(aluOp), 32'(mOp));
      checkOutput("cyc_disp", dispVal, mDisp);
    end
  end

  // One clean button press with operands set up first, then wait for it to take effect.
  task automatic applyStimulus(input logic [7:0] s, input logic [2:0] o, input int hold);
    @(negedge clk);
    sw = s;
    opSw = o;
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (Settle) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : mainFlow
    int found;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_stage", 32'(stage), 32'd0);
    checkOutput("rst_disp", dispVal, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_alu_a", aluA, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef BTN_DEBOUNCE_EN
    // A 10-cycle glitch is shorter than the filter window.
    @(negedge clk);
    sw = 8'h3C;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("db_glitch_stage", 32'(stage), 32'd0);

    // A 20-cycle press gives exactly one step, DB_CYC+3 cycles after the rise.
    btn = 1'b1;
    found = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 20) btn = 1'b0;
      if (found == 0 && stage == 2'd1) found = n;
    end
    checkOutput("db_step_latency", 32'(found), 32'(DB_CYC + 4));
    checkOutput("db_stage", 32'(stage), 32'd1);
    checkOutput("db_alu_a", aluA, 32'h3C);
`else
    // 5 + 3 with ADD
    applyStimulus(8'h05, 3'd0, 1);
    checkOutput("t2_stage_b", 32'(stage), 32'd1);
    checkOutput("t2_alu_a", aluA, 32'h5);
    applyStimulus(8'h03, 3'd0, 1);
    checkOutput("t2_alu_b", aluB, 32'h3);
    checkOutput("t2_alu_op", 32'(aluOp), 32'd0);
    checkOutput("t2_stage_show", 32'(stage), 32'd3);
    checkOutput("t2_disp", dispVal, 32'h8);
    checkOutput("t2_busy", 32'(busy), 32'd0);

    // Chain result 8 as A, then subtract 2
    applyStimulus(8'h00, 3'd0, 1);
    checkOutput("t3_alu_a", aluA, 32'h8);
    checkOutput("t3_stage", 32'(stage), 32'd1);
    applyStimulus(8'h02, 3'd1, 1);
    checkOutput("t3_alu_b", aluB, 32'h2);
    checkOutput("t3_alu_op", 32'(aluOp), 32'd1);
    checkOutput("t3_disp", dispVal, 32'h6);

    // Chain 6, XOR with 0x0F, wiggling op_sw through EXEC and SHOW
    applyStimulus(8'h00, 3'd0, 1);
    @(negedge clk);
    sw = 8'h0F;
    opSw = 3'd4;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      opSw = 3'(i);
    end
    checkOutput("t5_alu_op", 32'(aluOp), 32'd4);
    checkOutput("t5_disp", dispVal, 32'h9);
    opSw = 3'd0;

    // Reset in the middle of EXEC
    applyStimulus(8'h00, 3'd0, 1);
    @(negedge clk);
    sw = 8'h11;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (busy) found = 1;
    end
    checkOutput("t1_reach_exec", 32'(found), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("t1_stage", 32'(stage), 32'd0);
    checkOutput("t1_disp", dispVal, 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_alu_a", aluA, 32'd0);
    checkOutput("t1_alu_b", aluB, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Button held 50 cycles in LOAD_A: one step, three cycles of sync/edge latency
    @(negedge clk);
    sw = 8'hA5;
    btn = 1'b1;
    found = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (found == 0 && stage == 2'd1) found = n;
    end
    btn = 1'b0;
    repeat (Settle) @(negedge clk);
    checkOutput("t4_step_latency", 32'(found), 32'd4);
    checkOutput("t4_held_stage", 32'(stage), 32'd1);
    checkOutput("t4_alu_a", aluA, 32'hA5);

    // Second press lands while EXEC is running and must vanish
    @(negedge clk);
    sw = 8'h5A;
    opSw = 3'd3;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t4_exec_stage", 32'(stage), 32'd2);
    repeat (Settle) @(negedge clk);
    checkOutput("t4_show_stage", 32'(stage), 32'd3);
    checkOutput("t4_disp", dispVal, 32'hFF);
    checkOutput("t4_alu_b", aluB, 32'h5A);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
